// File: rtl/mcd_dram_axi_arbiter_if.sv
// Client-side and DRAM-side AXI4 bundle for the memcached DRAM arbiter.
// Modport master is the arbiter's view; slave is the clients plus DRAM controller.
interface mcd_dram_axi_arbiter_if #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 512,
  parameter int ID_WID   = 5,
  parameter int CH_BITS  = 2
);
  localparam int MID_WID  = ID_WID + CH_BITS;
  localparam int STRB_WID = DATA_WID / 8;

  logic [NUM_CH*ADDR_WID-1:0] s_araddr, s_awaddr;
  logic [NUM_CH*8-1:0]        s_arlen, s_awlen;
  logic [NUM_CH*3-1:0]        s_arsize, s_awsize;
  logic [NUM_CH*2-1:0]        s_arburst, s_awburst;
  logic [NUM_CH*ID_WID-1:0]   s_arid, s_awid;
  logic [NUM_CH-1:0]          s_arvalid, s_arready, s_awvalid, s_awready;

  logic [NUM_CH*DATA_WID-1:0] s_rdata, s_wdata;
  logic [NUM_CH*2-1:0]        s_rresp, s_bresp;
  logic [NUM_CH*ID_WID-1:0]   s_rid, s_bid;
  logic [NUM_CH-1:0]          s_rlast, s_rvalid, s_rready;
  logic [NUM_CH*STRB_WID-1:0] s_wstrb;
  logic [NUM_CH-1:0]          s_wlast, s_wvalid, s_wready;
  logic [NUM_CH-1:0]          s_bvalid, s_bready;

  logic [ADDR_WID-1:0] m_araddr, m_awaddr;
  logic [7:0]          m_arlen, m_awlen;
  logic [2:0]          m_arsize, m_awsize;
  logic [1:0]          m_arburst, m_awburst;
  logic [MID_WID-1:0]  m_arid, m_awid;
  logic                m_arvalid, m_arready, m_awvalid, m_awready;

  logic [DATA_WID-1:0] m_rdata, m_wdata;
  logic [1:0]          m_rresp, m_bresp;
  logic [MID_WID-1:0]  m_rid, m_bid;
  logic                m_rlast, m_rvalid, m_rready;
  logic [STRB_WID-1:0] m_wstrb;
  logic                m_wlast, m_wvalid, m_wready;
  logic                m_bvalid, m_bready;

  modport master (
    input  s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_arvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rid, s_rlast, s_rvalid,
    input  s_rready,
    input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bresp, s_bid, s_bvalid,
    input  s_bready,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rid, m_rlast, m_rvalid,
    output m_rready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awid, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bid, m_bvalid,
    output m_bready
  );

  modport slave (
    output s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rid, s_rlast, s_rvalid,
    output s_rready,
    output s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bid, s_bvalid,
    output s_bready,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rid, m_rlast, m_rvalid,
    input  m_rready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awid, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bid, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/mcd_dram_axi_arbiter.sv
// Round-robin merge of NUM_CH DRAM clients onto one AXI4 port; AR/AW 1-cycle registered, R/W/B combinational.
// Backpressure: address stage holds under !m_*ready; grants gated by per-channel read limit and W-order FIFO full.
module mcd_dram_axi_arbiter #(
  parameter int NUM_CH          = 3,
  parameter int ADDR_WID        = 32,
  parameter int DATA_WID        = 512,
  parameter int ID_WID          = 5,
  parameter int CH_BITS         = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WFIFO_DEPTH     = 4
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst,
  mcd_dram_axi_arbiter_if.master bus,
  output logic                  err_bad_id
);
  localparam int MID_WID  = ID_WID + CH_BITS;
  localparam int STRB_WID = DATA_WID / 8;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int WF_AW    = $clog2(WFIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WID-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [MID_WID-1:0]  id;
  } areq_t;

  // Returns {found, index}: first requester at or after ptr, wrapping at NUM_CH.
  function automatic logic [CH_BITS:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_BITS-1:0] ptr);
    logic [CH_BITS:0] res;
    int               idx;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) res = {1'b1, idx[CH_BITS-1:0]};
    end
    return res;
  endfunction

  function automatic logic [CH_BITS-1:0] next_ptr(input logic [CH_BITS-1:0] idx);
    return (idx == CH_BITS'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic areq_t mux_req(input logic [NUM_CH*ADDR_WID-1:0] addr,
                                    input logic [NUM_CH*8-1:0]        len,
                                    input logic [NUM_CH*3-1:0]        size,
                                    input logic [NUM_CH*2-1:0]        burst,
                                    input logic [NUM_CH*ID_WID-1:0]   id,
                                    input logic [CH_BITS-1:0]         ch);
    areq_t req;
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_BITS'(i)) begin
        req.addr  = addr[i*ADDR_WID +: ADDR_WID];
        req.len   = len[i*8 +: 8];
        req.size  = size[i*3 +: 3];
        req.burst = burst[i*2 +: 2];
        req.id    = {CH_BITS'(i), id[i*ID_WID +: ID_WID]};
      end
    end
    return req;
  endfunction

  // ---------------- AR ----------------
  logic [CH_BITS-1:0] r_ar_ptr;
  areq_t              r_ar;
  logic               r_ar_vld;
  logic [CNT_W-1:0]   r_rd_cnt [NUM_CH];
  logic [NUM_CH-1:0]  w_ar_elig;
  logic               w_ar_load, w_ar_found, w_ar_gnt;
  logic [CH_BITS-1:0] w_ar_idx;
  areq_t              w_ar_sel;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_ar_elig[i] = bus.s_arvalid[i] && (r_rd_cnt[i] < CNT_W'(MAX_OUTSTANDING));
  end

  assign w_ar_load              = !mem_rst && (!r_ar_vld || bus.m_arready);
  assign {w_ar_found, w_ar_idx} = rr_pick(w_ar_elig, r_ar_ptr);
  assign w_ar_gnt               = w_ar_load && w_ar_found;
  assign w_ar_sel = mux_req(bus.s_araddr, bus.s_arlen, bus.s_arsize, bus.s_arburst,
                            bus.s_arid, w_ar_idx);

  always_comb begin
    bus.s_arready = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_ar_idx == CH_BITS'(i)) bus.s_arready[i] = w_ar_gnt;
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      r_ar_vld <= 1'b0;
      r_ar_ptr <= '0;
      r_ar     <= '0;
    end else if (w_ar_gnt) begin
      r_ar     <= w_ar_sel;
      r_ar_vld <= 1'b1;
      r_ar_ptr <= next_ptr(w_ar_idx);
    end else if (bus.m_arready) begin
      r_ar_vld <= 1'b0;
    end
  end

  assign bus.m_araddr  = r_ar.addr;
  assign bus.m_arlen   = r_ar.len;
  assign bus.m_arsize  = r_ar.size;
  assign bus.m_arburst = r_ar.burst;
  assign bus.m_arid    = r_ar.id;
  assign bus.m_arvalid = r_ar_vld;

  // ---------------- R routing ----------------
  logic [CH_BITS-1:0] w_r_ch;
  logic               w_r_bad;
  logic [NUM_CH-1:0]  w_r_done;

  assign w_r_ch  = bus.m_rid[ID_WID +: CH_BITS];
  assign w_r_bad = ({1'b0, w_r_ch} >= (CH_BITS+1)'(NUM_CH));

  always_comb begin
    bus.s_rvalid = '0;
    bus.m_rready = 1'b1;   // unmatched channel index drains the beat
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_r_ch == CH_BITS'(i)) begin
        bus.s_rvalid[i] = bus.m_rvalid;
        bus.m_rready    = bus.s_rready[i];
      end
    end
  end

  assign bus.s_rdata = {NUM_CH{bus.m_rdata}};
  assign bus.s_rresp = {NUM_CH{bus.m_rresp}};
  assign bus.s_rid   = {NUM_CH{bus.m_rid[ID_WID-1:0]}};
  assign bus.s_rlast = {NUM_CH{bus.m_rlast}};
  assign w_r_done    = bus.s_rvalid & bus.s_rready & {NUM_CH{bus.m_rlast}};

  always_ff @(posedge mem_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (mem_rst)
        r_rd_cnt[i] <= '0;
      else if (bus.s_arready[i] && !w_r_done[i])
        r_rd_cnt[i] <= r_rd_cnt[i] + 1'b1;
      else if (!bus.s_arready[i] && w_r_done[i])
        r_rd_cnt[i] <= r_rd_cnt[i] - 1'b1;
    end
  end

  // ---------------- AW + W-order FIFO ----------------
  logic [CH_BITS-1:0] r_aw_ptr;
  areq_t              r_aw;
  logic               r_aw_vld;
  logic [CH_BITS-1:0] r_wf_mem [WFIFO_DEPTH];
  logic [WF_AW:0]     r_wf_wr, r_wf_rd;
  logic               w_wf_empty, w_wf_full, w_wf_pop;
  logic [CH_BITS-1:0] w_wf_head;
  logic               w_aw_load, w_aw_found, w_aw_gnt;
  logic [CH_BITS-1:0] w_aw_idx;
  areq_t              w_aw_sel;

  assign w_wf_empty = (r_wf_wr == r_wf_rd);
  assign w_wf_full  = (r_wf_wr[WF_AW] != r_wf_rd[WF_AW]) &&
                      (r_wf_wr[WF_AW-1:0] == r_wf_rd[WF_AW-1:0]);
  assign w_wf_head  = r_wf_mem[r_wf_rd[WF_AW-1:0]];
  assign w_wf_pop   = bus.m_wvalid && bus.m_wready && bus.m_wlast;

  // Full blocks the grant even when a pop lands in the same cycle.
  assign w_aw_load              = !mem_rst && (!r_aw_vld || bus.m_awready);
  assign {w_aw_found, w_aw_idx} = rr_pick(bus.s_awvalid & {NUM_CH{!w_wf_full}}, r_aw_ptr);
  assign w_aw_gnt               = w_aw_load && w_aw_found;
  assign w_aw_sel = mux_req(bus.s_awaddr, bus.s_awlen, bus.s_awsize, bus.s_awburst,
                            bus.s_awid, w_aw_idx);

  always_comb begin
    bus.s_awready = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_aw_idx == CH_BITS'(i)) bus.s_awready[i] = w_aw_gnt;
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      r_aw_vld <= 1'b0;
      r_aw_ptr <= '0;
      r_aw     <= '0;
    end else if (w_aw_gnt) begin
      r_aw     <= w_aw_sel;
      r_aw_vld <= 1'b1;
      r_aw_ptr <= next_ptr(w_aw_idx);
    end else if (bus.m_awready) begin
      r_aw_vld <= 1'b0;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      r_wf_wr <= '0;
      r_wf_rd <= '0;
    end else begin
      if (w_aw_gnt) r_wf_wr <= r_wf_wr + 1'b1;
      if (w_wf_pop) r_wf_rd <= r_wf_rd + 1'b1;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (w_aw_gnt) r_wf_mem[r_wf_wr[WF_AW-1:0]] <= w_aw_idx;
  end

  assign bus.m_awaddr  = r_aw.addr;
  assign bus.m_awlen   = r_aw.len;
  assign bus.m_awsize  = r_aw.size;
  assign bus.m_awburst = r_aw.burst;
  assign bus.m_awid    = r_aw.id;
  assign bus.m_awvalid = r_aw_vld;

  always_comb begin
    bus.m_wdata  = '0;
    bus.m_wstrb  = '0;
    bus.m_wlast  = 1'b0;
    bus.m_wvalid = 1'b0;
    bus.s_wready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_wf_empty && (w_wf_head == CH_BITS'(i))) begin
        bus.m_wdata     = bus.s_wdata[i*DATA_WID +: DATA_WID];
        bus.m_wstrb     = bus.s_wstrb[i*STRB_WID +: STRB_WID];
        bus.m_wlast     = bus.s_wlast[i];
        bus.m_wvalid    = bus.s_wvalid[i];
        bus.s_wready[i] = bus.m_wready;
      end
    end
  end

  // ---------------- B routing ----------------
  logic [CH_BITS-1:0] w_b_ch;
  logic               w_b_bad;
  logic               r_err_bad_id;

  assign w_b_ch  = bus.m_bid[ID_WID +: CH_BITS];
  assign w_b_bad = ({1'b0, w_b_ch} >= (CH_BITS+1)'(NUM_CH));

  always_comb begin
    bus.s_bvalid = '0;
    bus.m_bready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_b_ch == CH_BITS'(i)) begin
        bus.s_bvalid[i] = bus.m_bvalid;
        bus.m_bready    = bus.s_bready[i];
      end
    end
  end

  assign bus.s_bresp = {NUM_CH{bus.m_bresp}};
  assign bus.s_bid   = {NUM_CH{bus.m_bid[ID_WID-1:0]}};

  always_ff @(posedge mem_clk) begin
    if (mem_rst)
      r_err_bad_id <= 1'b0;
    else if ((bus.m_rvalid && w_r_bad) || (bus.m_bvalid && w_b_bad))
      r_err_bad_id <= 1'b1;
  end

  assign err_bad_id = r_err_bad_id;
endmodule

// File: tb/tb_mcd_dram_axi_arbiter.sv
// Directed bench for mcd_dram_axi_arbiter: NUM_CH=3, MAX_OUTSTANDING=2, WFIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_mcd_dram_axi_arbiter;
  localparam int NUM_CH = 3, ADDR_WID = 32, DATA_WID = 64, ID_WID = 5, CH_BITS = 2;
  localparam int MAX_OUTSTANDING = 2, WFIFO_DEPTH = 4;

  logic mem_clk = 1'b0;
  logic mem_rst;
  logic err_bad_id;
  int   n_chk, n_err;
  logic [31:0] t2_addr [3];

  mcd_dram_axi_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID),
                            .ID_WID(ID_WID), .CH_BITS(CH_BITS)) bus ();

  mcd_dram_axi_arbiter #(.NUM_CH(NUM_CH), .ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID),
                         .ID_WID(ID_WID), .CH_BITS(CH_BITS),
                         .MAX_OUTSTANDING(MAX_OUTSTANDING), .WFIFO_DEPTH(WFIFO_DEPTH)) dut (
    .mem_clk    (mem_clk),
    .mem_rst    (mem_rst),
    .bus        (bus),
    .err_bad_id (err_bad_id)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic clr;
    bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0; bus.s_arburst = '0;
    bus.s_arid = '0; bus.s_arvalid = '0; bus.s_rready = '0;
    bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0; bus.s_awburst = '0;
    bus.s_awid = '0; bus.s_awvalid = '0;
    bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = '0; bus.s_wvalid = '0;
    bus.s_bready = '0;
    bus.m_arready = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rid = '0; bus.m_rlast = 1'b0; bus.m_rvalid = 1'b0;
    bus.m_bresp = '0; bus.m_bid = '0; bus.m_bvalid = 1'b0;
  endtask

  task automatic do_reset;
    clr();
    mem_rst = 1'b1;
    tick();
    mem_rst = 1'b0;
  endtask

  task automatic set_ar(input int ch, input logic [31:0] addr, input logic [4:0] id,
                        input logic [7:0] len);
    bus.s_araddr[ch*32 +: 32] = addr;
    bus.s_arid[ch*5 +: 5]     = id;
    bus.s_arlen[ch*8 +: 8]    = len;
  endtask

  task automatic set_aw(input int ch, input logic [31:0] addr, input logic [4:0] id,
                        input logic [7:0] len);
    bus.s_awaddr[ch*32 +: 32] = addr;
    bus.s_awid[ch*5 +: 5]     = id;
    bus.s_awlen[ch*8 +: 8]    = len;
  endtask

  task automatic set_w(input int ch, input logic [63:0] data, input logic last);
    bus.s_wdata[ch*64 +: 64] = data;
    bus.s_wstrb[ch*8 +: 8]   = 8'hFF;
    bus.s_wlast[ch]          = last;
  endtask

  initial begin
    logic [2:0] exp_oh;
    n_chk = 0;
    n_err = 0;
    t2_addr[0] = 32'h100; t2_addr[1] = 32'h200; t2_addr[2] = 32'h300;

    // Reset state, with requests held high to show reset blocks grants
    clr();
    mem_rst = 1'b1;
    bus.s_arvalid = 3'b111;
    bus.s_awvalid = 3'b111;
    bus.m_arready = 1'b1;
    bus.m_awready = 1'b1;
    repeat (3) tick();
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_m_awvalid", bus.m_awvalid, 1'b0);
    chk("rst_m_wvalid", bus.m_wvalid, 1'b0);
    chk("rst_s_arready", bus.s_arready, 3'b000);
    chk("rst_s_awready", bus.s_awready, 3'b000);
    chk("rst_s_wready", bus.s_wready, 3'b000);
    chk("rst_err", err_bad_id, 1'b0);
    clr();
    mem_rst = 1'b0;

    // Single read from ch1, routed response
    set_ar(1, 32'h1000, 5'd3, 8'd0);
    bus.s_arvalid = 3'b010;
    bus.m_arready = 1'b1;
    #1;
    chk("t1_arready", bus.s_arready, 3'b010);
    tick();
    bus.s_arvalid = 3'b000;
    #1;
    chk("t1_m_arvalid", bus.m_arvalid, 1'b1);
    chk("t1_m_arid", bus.m_arid, 7'h23);
    chk("t1_m_araddr", bus.m_araddr, 32'h1000);
    tick();
    chk("t1_m_arvalid_drop", bus.m_arvalid, 1'b0);
    bus.m_rvalid = 1'b1; bus.m_rid = 7'h23; bus.m_rdata = 64'hDEAD; bus.m_rlast = 1'b1;
    bus.s_rready = 3'b101;
    #1;
    chk("t1_s_rvalid", bus.s_rvalid, 3'b010);
    chk("t1_s_rid", bus.s_rid[9:5], 5'd3);
    chk("t1_s_rdata", bus.s_rdata[127:64], 64'hDEAD);
    chk("t1_m_rready_other", bus.m_rready, 1'b0);
    bus.s_rready = 3'b010;
    #1;
    chk("t1_m_rready_own", bus.m_rready, 1'b1);
    tick();
    bus.m_rvalid = 1'b0;
    bus.s_rready = 3'b000;

    // Round-robin with all channels requesting, no gaps
    do_reset();
    set_ar(0, t2_addr[0], 5'd0, 8'd0);
    set_ar(1, t2_addr[1], 5'd0, 8'd0);
    set_ar(2, t2_addr[2], 5'd0, 8'd0);
    bus.s_arvalid = 3'b111;
    bus.m_arready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_oh = 3'b001 << (g % 3);
      #1;
      chk("t2_gnt", bus.s_arready, exp_oh);
      tick();
      chk("t2_m_arvalid", bus.m_arvalid, 1'b1);
      chk("t2_m_araddr", bus.m_araddr, t2_addr[g % 3]);
    end
    #1;
    chk("t2_all_at_limit", bus.s_arready, 3'b000);
    bus.s_arvalid = 3'b000;

    // Outstanding limit on ch0, ch2 proceeds
    do_reset();
    bus.m_arready = 1'b1;
    set_ar(0, 32'h400, 5'd1, 8'd0);
    set_ar(2, 32'h800, 5'd2, 8'd0);
    bus.s_arvalid = 3'b001;
    #1;
    chk("t3_g1", bus.s_arready, 3'b001);
    tick();
    #1;
    chk("t3_g2", bus.s_arready, 3'b001);
    tick();
    bus.s_arvalid = 3'b101;
    #1;
    chk("t3_skip_ch0", bus.s_arready, 3'b100);
    tick();
    bus.s_arvalid = 3'b001;
    #1;
    chk("t3_held", bus.s_arready, 3'b000);
    chk("t3_m_araddr_ch2", bus.m_araddr, 32'h800);
    chk("t3_m_arid_ch2", bus.m_arid, 7'h42);
    bus.m_rvalid = 1'b1; bus.m_rid = 7'h01; bus.m_rlast = 1'b1; bus.s_rready = 3'b001;
    #1;
    chk("t3_s_rvalid", bus.s_rvalid, 3'b001);
    tick();
    bus.m_rvalid = 1'b0;
    bus.s_rready = 3'b000;
    #1;
    chk("t3_release", bus.s_arready, 3'b001);
    tick();
    chk("t3_m_araddr_ch0", bus.m_araddr, 32'h400);
    bus.s_arvalid = 3'b000;

    // Write ordering: ch2 (2 beats) before ch0
    do_reset();
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    set_aw(2, 32'h2000, 5'd5, 8'd1);
    bus.s_awvalid = 3'b100;
    #1;
    chk("t4_aw_g1", bus.s_awready, 3'b100);
    tick();
    set_aw(0, 32'h3000, 5'd4, 8'd0);
    bus.s_awvalid = 3'b001;
    set_w(0, 64'hA0, 1'b1);
    bus.s_wvalid = 3'b001;
    #1;
    chk("t4_aw_g2", bus.s_awready, 3'b001);
    chk("t4_m_awid", bus.m_awid, 7'h45);
    chk("t4_w_blocked", bus.s_wready, 3'b100);
    chk("t4_m_wvalid_none", bus.m_wvalid, 1'b0);
    tick();
    bus.s_awvalid = 3'b000;
    set_w(2, 64'hC0, 1'b0);
    bus.s_wvalid = 3'b101;
    #1;
    chk("t4_b0_vld", bus.m_wvalid, 1'b1);
    chk("t4_b0_data", bus.m_wdata, 64'hC0);
    chk("t4_b0_last", bus.m_wlast, 1'b0);
    chk("t4_b0_wready", bus.s_wready, 3'b100);
    tick();
    set_w(2, 64'hC1, 1'b1);
    #1;
    chk("t4_b1_data", bus.m_wdata, 64'hC1);
    chk("t4_b1_last", bus.m_wlast, 1'b1);
    chk("t4_b1_wready", bus.s_wready, 3'b100);
    tick();
    bus.s_wvalid = 3'b001;
    #1;
    chk("t4_ch0_vld", bus.m_wvalid, 1'b1);
    chk("t4_ch0_data", bus.m_wdata, 64'hA0);
    chk("t4_ch0_wready", bus.s_wready, 3'b001);
    tick();
    bus.s_wvalid = 3'b000;
    #1;
    chk("t4_empty_vld", bus.m_wvalid, 1'b0);
    chk("t4_empty_wready", bus.s_wready, 3'b000);
    bus.m_bvalid = 1'b1; bus.m_bid = 7'h47; bus.s_bready = 3'b100;
    #1;
    chk("t4_s_bvalid", bus.s_bvalid, 3'b100);
    chk("t4_s_bid", bus.s_bid[14:10], 5'd7);
    chk("t4_m_bready", bus.m_bready, 1'b1);
    tick();
    bus.m_bvalid = 1'b0;
    bus.s_bready = 3'b000;

    // W FIFO full after four AW grants
    do_reset();
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    bus.s_awvalid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      exp_oh = 3'b001 << (g % 3);
      #1;
      chk("t5_gnt", bus.s_awready, exp_oh);
      tick();
    end
    #1;
    chk("t5_full", bus.s_awready, 3'b000);
    tick();
    set_w(0, 64'hB0, 1'b1);
    bus.s_wvalid = 3'b001;
    #1;
    chk("t5_full_during_pop", bus.s_awready, 3'b000);
    chk("t5_m_wvalid", bus.m_wvalid, 1'b1);
    chk("t5_s_wready", bus.s_wready, 3'b001);
    tick();
    bus.s_wvalid = 3'b000;
    #1;
    chk("t5_regrant", bus.s_awready, 3'b010);
    tick();
    bus.s_awvalid = 3'b000;

    // Out-of-range channel index on R and B
    bus.m_rvalid = 1'b1; bus.m_rid = 7'h61; bus.s_rready = 3'b000;
    #1;
    chk("t6_r_drain", bus.m_rready, 1'b1);
    chk("t6_r_no_vld", bus.s_rvalid, 3'b000);
    chk("t6_err_not_yet", err_bad_id, 1'b0);
    tick();
    bus.m_rvalid = 1'b0;
    chk("t6_err_set", err_bad_id, 1'b1);
    bus.m_bvalid = 1'b1; bus.m_bid = 7'h61; bus.s_bready = 3'b000;
    #1;
    chk("t6_b_drain", bus.m_bready, 1'b1);
    chk("t6_b_no_vld", bus.s_bvalid, 3'b000);
    tick();
    bus.m_bvalid = 1'b0;
    chk("t6_err_sticky", err_bad_id, 1'b1);

    // Held AR stage stays stable, then reset mid-burst
    bus.m_arready = 1'b0;
    set_ar(1, 32'h5000, 5'd6, 8'd3);
    bus.s_arvalid = 3'b010;
    tick();
    set_ar(1, 32'h6000, 5'd6, 8'd3);
    tick();
    chk("t7_hold_vld", bus.m_arvalid, 1'b1);
    chk("t7_hold_addr", bus.m_araddr, 32'h5000);
    set_w(0, 64'h1, 1'b0);
    set_w(1, 64'h2, 1'b0);
    set_w(2, 64'h3, 1'b0);
    bus.s_wvalid = 3'b111;
    #1;
    chk("t7_pre_wvalid", bus.m_wvalid, 1'b1);
    mem_rst = 1'b1;
    bus.s_arvalid = 3'b111;
    tick();
    chk("t7_rst_arvalid", bus.m_arvalid, 1'b0);
    chk("t7_rst_wvalid", bus.m_wvalid, 1'b0);
    chk("t7_rst_arready", bus.s_arready, 3'b000);
    chk("t7_rst_wready", bus.s_wready, 3'b000);
    chk("t7_rst_err", err_bad_id, 1'b0);
    mem_rst = 1'b0;
    clr();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
